// File: rtl/axi_wr_slave_mem.sv
// AXI3 write-only slave backed by a byte-lane-writable word memory.
// One outstanding burst: AW capture, W beats, then a single B response.
module axi_wr_slave_mem #(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ID_WIDTH   = 4,
   parameter int unsigned MEM_WORDS  = 1024,
   localparam int unsigned STRB_W    = DATA_WIDTH / 8,
   localparam int unsigned IDX_W     = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1
) (
   input  logic                  aclk,
   input  logic                  areset,
   input  logic [ID_WIDTH-1:0]   awid,
   input  logic [ADDR_WIDTH-1:0] awaddr,
   input  logic [3:0]            awlen,
   input  logic [2:0]            awsize,
   input  logic [1:0]            awburst,
   input  logic                  awvalid,
   output logic                  awready,
   input  logic [ID_WIDTH-1:0]   wid,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic [STRB_W-1:0]     wstrb,
   input  logic                  wlast,
   input  logic                  wvalid,
   output logic                  wready,
   output logic [ID_WIDTH-1:0]   bid,
   output logic [1:0]            bresp,
   output logic                  bvalid,
   input  logic                  bready,
   input  logic [IDX_W-1:0]      dbg_addr,
   output logic [DATA_WIDTH-1:0] dbg_rdata
);

   localparam int unsigned OFF_W = $clog2(STRB_W);
   localparam logic [IDX_W:0] MemWordsW = (IDX_W + 1)'(MEM_WORDS);

   typedef enum logic [1:0] {StIdle, StData, StResp} state_e;

   state_e                state_q, state_d;
   logic [ID_WIDTH-1:0]   id_q, id_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [3:0]            len_q, len_d;
   logic [2:0]            size_q, size_d;
   logic [1:0]            burst_q, burst_d;
   logic [3:0]            beat_q, beat_d;
   logic                  bad_q, bad_d;   // burst illegal: accept beats, write nothing
   logic                  err_q, err_d;

   logic [DATA_WIDTH-1:0] mem_q [MEM_WORDS];

   logic                  aw_bad;
   logic [ADDR_WIDTH-1:0] addr_inc, wrap_len, wrap_mask, addr_nxt, word_idx;
   logic                  in_range, beat_last, mem_we;

   assign awready = (state_q == StIdle) && !areset;
   assign wready  = (state_q == StData) && !areset;
   assign bvalid  = (state_q == StResp);
   assign bid     = id_q;
   assign bresp   = (state_q == StResp && err_q) ? 2'b10 : 2'b00;

   // Burst legality and per-beat address arithmetic
   always_comb begin
      aw_bad = (awsize > 3'(OFF_W)) || (awburst == 2'b11) ||
               ((awburst == 2'b10) &&
                !((awlen == 4'd1) || (awlen == 4'd3) || (awlen == 4'd7) || (awlen == 4'd15)));
      addr_inc  = addr_q + ({{(ADDR_WIDTH-1){1'b0}}, 1'b1} << size_q);
      // Legal WRAP totals are powers of two, so the boundary is a simple mask.
      wrap_len  = ADDR_WIDTH'({1'b0, len_q} + 5'd1) << size_q;
      wrap_mask = wrap_len - 1'b1;
      unique case (burst_q)
         2'b00:   addr_nxt = addr_q;
         2'b10:   addr_nxt = (addr_q & ~wrap_mask) | (addr_inc & wrap_mask);
         default: addr_nxt = addr_inc;
      endcase
      word_idx  = addr_q >> OFF_W;
      in_range  = word_idx < ADDR_WIDTH'(MEM_WORDS);
      beat_last = (beat_q == len_q);
   end

   // Next-state logic for the AW -> W -> B sequence
   always_comb begin
      state_d = state_q;
      id_d    = id_q;
      addr_d  = addr_q;
      len_d   = len_q;
      size_d  = size_q;
      burst_d = burst_q;
      beat_d  = beat_q;
      bad_d   = bad_q;
      err_d   = err_q;
      mem_we  = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (awvalid && awready) begin
               id_d    = awid;
               addr_d  = awaddr;
               len_d   = awlen;
               size_d  = awsize;
               burst_d = awburst;
               beat_d  = '0;
               bad_d   = aw_bad;
               err_d   = aw_bad;
               state_d = StData;
            end
         end
         StData: begin
            if (wvalid && wready) begin
               if (wlast != beat_last) err_d = 1'b1;
               if (!bad_q) begin
                  if (in_range && (wid == id_q)) mem_we = 1'b1;
                  else                           err_d  = 1'b1;
               end
               if (wlast || beat_last) begin
                  state_d = StResp;
               end else begin
                  beat_d = beat_q + 4'd1;
                  addr_d = addr_nxt;
               end
            end
         end
         StResp: begin
            if (bready) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // Control registers with synchronous reset
   always_ff @(posedge aclk) begin
      if (areset) begin
         state_q <= StIdle;
         id_q    <= '0;
         addr_q  <= '0;
         len_q   <= '0;
         size_q  <= '0;
         burst_q <= '0;
         beat_q  <= '0;
         bad_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         id_q    <= id_d;
         addr_q  <= addr_d;
         len_q   <= len_d;
         size_q  <= size_d;
         burst_q <= burst_d;
         beat_q  <= beat_d;
         bad_q   <= bad_d;
         err_q   <= err_d;
      end
   end

   // Backing store: byte-lane writes, never cleared by reset
   always_ff @(posedge aclk) begin
      if (mem_we) begin
         for (int i = 0; i < int'(STRB_W); i++) begin
            if (wstrb[i]) mem_q[word_idx[IDX_W-1:0]][8*i +: 8] <= wdata[8*i +: 8];
         end
      end
   end

   // Backdoor read; indices past a non-power-of-two depth return zero
   always_comb begin
      dbg_rdata = '0;
      if ({1'b0, dbg_addr} < MemWordsW) dbg_rdata = mem_q[dbg_addr];
   end

endmodule

// File: tb/tb_axi_wr_slave_mem.sv
// Randomised bench for axi_wr_slave_mem with a byte-level reference memory.
module tb_axi_wr_slave_mem;

   localparam int MW = 1024;

   logic        aclk = 1'b0;
   logic        areset;
   logic [3:0]  awid;
   logic [31:0] awaddr;
   logic [3:0]  awlen;
   logic [2:0]  awsize;
   logic [1:0]  awburst;
   logic        awvalid;
   logic        awready;
   logic [3:0]  wid;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        wlast;
   logic        wvalid;
   logic        wready;
   logic [3:0]  bid;
   logic [1:0]  bresp;
   logic        bvalid;
   logic        bready;
   logic [9:0]  dbg_addr;
   logic [31:0] dbg_rdata;

   axi_wr_slave_mem dut (
      .aclk      (aclk),
      .areset    (areset),
      .awid      (awid),
      .awaddr    (awaddr),
      .awlen     (awlen),
      .awsize    (awsize),
      .awburst   (awburst),
      .awvalid   (awvalid),
      .awready   (awready),
      .wid       (wid),
      .wdata     (wdata),
      .wstrb     (wstrb),
      .wlast     (wlast),
      .wvalid    (wvalid),
      .wready    (wready),
      .bid       (bid),
      .bresp     (bresp),
      .bvalid    (bvalid),
      .bready    (bready),
      .dbg_addr  (dbg_addr),
      .dbg_rdata (dbg_rdata)
   );

   always #5 aclk = ~aclk;

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   logic [31:0] model_mem [MW];
   logic [3:0]  known     [MW];
   logic [31:0] beat_data [16];
   logic [3:0]  beat_strb [16];
   logic [3:0]  beat_wid  [16];

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] lane_mask(input logic [3:0] m);
      logic [31:0] r;
      for (int i = 0; i < 4; i++) r[8*i +: 8] = {8{m[i]}};
      return r;
   endfunction

   task automatic model_write(input int w, input logic [31:0] d, input logic [3:0] s);
      logic [31:0] m;
      m = lane_mask(s);
      model_mem[w] = (model_mem[w] & ~m) | (d & m);
      known[w]     = known[w] | s;
   endtask

   task automatic read_word(input int w, output logic [31:0] d);
      dbg_addr = w[9:0];
      #1;
      d = dbg_rdata;
   endtask

   // Compares only bytes the model has a defined value for
   task automatic check_word(input int w, input string tag);
      logic [31:0] d, m;
      read_word(w, d);
      m = lane_mask(known[w]);
      check_eq(tag, d & m, model_mem[w] & m);
   endtask

   task automatic fill_random(input logic [3:0] id, input bit full_strb);
      for (int i = 0; i < 16; i++) begin
         beat_data[i] = $urandom;
         beat_strb[i] = full_strb ? 4'hF : 4'($urandom);
         beat_wid[i]  = ($urandom % 10 == 0) ? (id ^ 4'h1) : id;
      end
   endtask

   // Runs one burst; call and return at a falling edge. wlast_pos > len means
   // wlast is never sent. abort_beat >= 0 resets the DUT after that beat.
   task automatic do_burst(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                           input logic [2:0] size, input logic [1:0] burst, input int wlast_pos,
                           input int bdelay, input bit early_w, input int abort_beat);
      bit             bad, err, last;
      int             cnt, word;
      longint unsigned a, inc, tsz, bound;
      bad = (size > 3'd2) || (burst == 2'b11) ||
            ((burst == 2'b10) && !(len == 1 || len == 3 || len == 7 || len == 15));
      err   = bad;
      inc   = longint'(1) << size;
      tsz   = inc * (longint'(len) + 1);
      bound = (longint'(addr) / tsz) * tsz;
      a     = addr;

      awvalid = 1'b1; awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst;
      if (early_w) begin
         wvalid = 1'b1; wdata = beat_data[0]; wstrb = beat_strb[0]; wid = beat_wid[0];
         wlast = (wlast_pos == 0);
      end
      cnt = 0;
      while (!awready && cnt < 20) begin @(negedge aclk); cnt++; end
      if (!awready) begin
         check_eq("aw_timeout", 0, 1);
         awvalid = 1'b0; wvalid = 1'b0;
         return;
      end
      if (early_w) check_eq("wready_in_idle", {63'd0, wready}, 0);
      @(negedge aclk);
      awvalid = 1'b0;
      check_eq("wready_after_aw", {63'd0, wready}, 1);

      for (int b = 0; b <= int'(len); b++) begin
         wvalid = 1'b1; wdata = beat_data[b]; wstrb = beat_strb[b]; wid = beat_wid[b];
         wlast  = (b == wlast_pos);
         cnt = 0;
         while (!wready && cnt < 20) begin @(negedge aclk); cnt++; end
         if (!wready) begin
            check_eq("w_timeout", 0, 1);
            wvalid = 1'b0;
            return;
         end
         @(posedge aclk);
         last = (b == wlast_pos) || (b == int'(len));
         if ((b == wlast_pos) != (b == int'(len))) err = 1'b1;
         word = int'(a >> 2);
         if (!bad) begin
            if (word >= MW || beat_wid[b] != id) err = 1'b1;
            else model_write(word, beat_data[b], beat_strb[b]);
         end
         @(negedge aclk);
         wvalid = 1'b0; wlast = 1'b0;
         if (word < MW) check_word(word, "mem_after_beat");
         if (b == abort_beat) begin
            areset = 1'b1;
            @(posedge aclk);
            @(negedge aclk);
            check_eq("rst_bvalid", {63'd0, bvalid}, 0);
            check_eq("rst_wready", {63'd0, wready}, 0);
            check_eq("rst_awready", {63'd0, awready}, 0);
            areset = 1'b0;
            #1;
            check_eq("awready_after_abort", {63'd0, awready}, 1);
            @(negedge aclk);
            check_eq("no_b_after_abort", {63'd0, bvalid}, 0);
            return;
         end
         if (last) break;
         if (burst != 2'b00) a = a + inc;
         if (burst == 2'b10 && a >= bound + tsz) a = bound;
         if ($urandom % 4 == 0) @(negedge aclk);
      end

      check_eq("bvalid_latency", {63'd0, bvalid}, 1);
      check_eq("bid", {60'd0, bid}, {60'd0, id});
      check_eq("bresp", {62'd0, bresp}, err ? 64'd2 : 64'd0);
      for (int d = 0; d < bdelay; d++) begin
         @(negedge aclk);
         check_eq("b_hold_valid", {63'd0, bvalid}, 1);
         check_eq("b_hold_id", {60'd0, bid}, {60'd0, id});
         check_eq("b_hold_resp", {62'd0, bresp}, err ? 64'd2 : 64'd0);
         check_eq("awready_in_resp", {63'd0, awready}, 0);
      end
      bready = 1'b1;
      @(posedge aclk);
      @(negedge aclk);
      bready = 1'b0;
      check_eq("bvalid_after_b", {63'd0, bvalid}, 0);
      check_eq("awready_after_b", {63'd0, awready}, 1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got=timeout expected=finish");
      $fatal(1);
   end

   initial begin
      logic [31:0] d;
      logic [3:0]  id;
      int          len, wp;
      logic [31:0] addr;
      for (int i = 0; i < MW; i++) begin model_mem[i] = '0; known[i] = '0; end
      areset = 1'b1; awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0; wlast = 1'b0;
      awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0;
      wid = '0; wdata = '0; wstrb = '0; dbg_addr = '0;

      repeat (3) @(negedge aclk);
      check_eq("reset_awready", {63'd0, awready}, 0);
      check_eq("reset_wready", {63'd0, wready}, 0);
      check_eq("reset_bvalid", {63'd0, bvalid}, 0);
      check_eq("reset_bresp", {62'd0, bresp}, 0);
      check_eq("reset_bid", {60'd0, bid}, 0);
      areset = 1'b0;
      #1;
      check_eq("awready_after_reset", {63'd0, awready}, 1);
      @(negedge aclk);

      // INCR, four full words at 0x10
      for (int i = 0; i < 4; i++) begin
         beat_data[i] = 32'hA0 + i; beat_strb[i] = 4'hF; beat_wid[i] = 4'h5;
      end
      do_burst(4'h5, 32'h10, 4'd3, 3'd2, 2'b01, 3, 0, 1'b0, -1);
      for (int i = 0; i < 4; i++) begin
         read_word(4 + i, d);
         check_eq("incr_word", d, 32'hA0 + i);
      end

      // WRAP starting at 0x38
      for (int i = 0; i < 4; i++) begin
         beat_data[i] = 32'hB0 + i; beat_strb[i] = 4'hF; beat_wid[i] = 4'h6;
      end
      do_burst(4'h6, 32'h38, 4'd3, 3'd2, 2'b10, 3, 1, 1'b1, -1);
      read_word(14, d); check_eq("wrap_0x38", d, 32'hB0);
      read_word(15, d); check_eq("wrap_0x3c", d, 32'hB1);
      read_word(12, d); check_eq("wrap_0x30", d, 32'hB2);
      read_word(13, d); check_eq("wrap_0x34", d, 32'hB3);

      // Partial strobe merge
      beat_data[0] = 32'hFFFF_FFFF; beat_strb[0] = 4'hF; beat_wid[0] = 4'h2;
      do_burst(4'h2, 32'h20, 4'd0, 3'd2, 2'b01, 0, 0, 1'b0, -1);
      beat_data[0] = 32'h1234_5678; beat_strb[0] = 4'b0101;
      do_burst(4'h2, 32'h20, 4'd0, 3'd2, 2'b01, 0, 0, 1'b0, -1);
      read_word(8, d); check_eq("strobe_merge", d, 32'hFF34_FF78);

      // Early wlast, out-of-range address, B backpressure
      fill_random(4'h3, 1'b1);
      for (int i = 0; i < 16; i++) beat_wid[i] = 4'h3;
      do_burst(4'h3, 32'h40, 4'd3, 3'd2, 2'b01, 1, 0, 1'b0, -1);
      do_burst(4'h3, 32'h1000, 4'd0, 3'd2, 2'b01, 0, 0, 1'b0, -1);
      do_burst(4'h9, 32'h80, 4'd1, 3'd2, 2'b01, 1, 5, 1'b0, -1);

      // Reset after first of four beats
      beat_data[0] = 32'h1111_1111; beat_data[1] = 32'h2222_2222;
      beat_strb[0] = 4'hF; beat_strb[1] = 4'hF; beat_wid[0] = 4'h1; beat_wid[1] = 4'h1;
      do_burst(4'h1, 32'h0, 4'd1, 3'd2, 2'b01, 1, 0, 1'b0, -1);
      beat_data[0] = 32'hCAFE_0000; beat_data[1] = 32'hCAFE_0001;
      do_burst(4'h1, 32'h0, 4'd3, 3'd2, 2'b01, 3, 0, 1'b0, 0);
      read_word(0, d); check_eq("abort_word0", d, 32'hCAFE_0000);
      read_word(1, d); check_eq("abort_word1", d, 32'h2222_2222);

      // Randomised bursts
      for (int n = 0; n < 80; n++) begin
         id  = 4'($urandom);
         len = $urandom % 16;
         wp  = len;
         if ($urandom % 8 == 0) wp = $urandom % (len + 1);
         else if ($urandom % 8 == 0) wp = 16;
         addr = (($urandom % 10) == 0) ? (32'hFF0 + ($urandom % 32)) : ($urandom % 256);
         fill_random(id, ($urandom % 2) == 1);
         do_burst(id, addr, 4'(len), (($urandom % 6) == 0) ? 3'd3 : 3'($urandom % 3),
                  2'($urandom), wp, $urandom % 4, ($urandom % 2) == 1, -1);
      end

      for (int w = 0; w < 128; w++) check_word(w, "sweep_low");
      for (int w = MW - 8; w < MW; w++) check_word(w, "sweep_high");

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/axi_wr_slave_mem.md
AXI_WR_SLAVE_MEM -- requirements
Module: axi_wr_slave_mem

Interface
REQ-001 SHALL have one clock and synchronous, active-high reset: aclk (rising edge), areset (synchronous, active-high).
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, byte address width.
REQ-003 SHALL have parameter DATA_WIDTH, default 32, data bus width in bits (legal: 32, 64, 128); STRB_W = DATA_WIDTH/8.
REQ-004 SHALL have parameter ID_WIDTH, default 4, transaction ID width.
REQ-005 SHALL have parameter MEM_WORDS, default 1024, backing-store depth in DATA_WIDTH words.
REQ-006 SHALL have the following ports (name, direction, width, meaning):
- aclk in 1 clock
- areset in 1 sync reset, active-high
- awid in ID_WIDTH write address ID
- awaddr in ADDR_WIDTH start byte address
- awlen in 4 beats-1 (AXI3, 1..16 beats)
- awsize in 3 bytes per beat = 2**awsize
- awburst in 2 00 FIXED, 01 INCR, 10 WRAP, 11 reserved
- awvalid in 1 AW valid
- awready out 1 AW ready
- wid in ID_WIDTH write data ID
- wdata in DATA_WIDTH write data
- wstrb in STRB_W byte strobes
- wlast in 1 last beat
- wvalid in 1 W valid
- wready out 1 W ready
- bid out ID_WIDTH response ID (= accepted awid)
- bresp out 2 00 OKAY, 10 SLVERR
- bvalid out 1 B valid
- bready in 1 B ready
- dbg_addr in log2(MEM_WORDS) backdoor word index
- dbg_rdata out DATA_WIDTH backdoor word, combinational read

Function
REQ-007 SHALL implement FSM IDLE -> DATA -> RESP -> IDLE, one outstanding write.
REQ-008 awready SHALL be 1 only in IDLE. On the awvalid&awready edge, the block SHALL capture awid/awaddr/awlen/awsize/awburst, clear the error flag and the beat counter, and go to DATA.
REQ-009 wready SHALL be 1 only in DATA; AW accepted at cycle N -> wready=1 at N+1; wvalid before then SHALL be ignored.
REQ-010 Each accepted beat SHALL write byte lane i of word (addr>>log2(STRB_W)) iff wstrb[i]=1. Other lanes SHALL be unchanged.
REQ-011 Beat address update: FIXED unchanged; INCR addr += 2**awsize; WRAP addr += 2**awsize, wrapping to boundary = floor(start/T)*T when reaching boundary+T, where T = (2**awsize)*(awlen+1).
REQ-012 DATA SHALL end on the beat where wlast=1 or beat count = awlen, whichever comes first.
REQ-013 The transaction SHALL set SLVERR if wlast is asserted on a beat other than beat awlen, or if wlast is absent on beat awlen.
REQ-014 The following SHALL set SLVERR and suppress all memory writes for the burst; beats are still accepted to drain:
- awsize > log2(STRB_W)
- awburst=11
- WRAP with awlen not in {1,3,7,15}
REQ-015 A beat with word index >= MEM_WORDS, or with wid != captured awid, SHALL NOT be written and SHALL set SLVERR; the other beats of the burst SHALL still be written.
REQ-016 The last beat accepted at cycle M SHALL give RESP with bvalid=1, bid=awid and bresp at M+1.
REQ-017 bvalid/bid/bresp SHALL hold stable until bready=1.
REQ-018 After the B handshake at cycle K, the FSM SHALL be in IDLE with awready=1 at K+1 (one bubble between bursts).
REQ-019 A simultaneous awvalid in RESP SHALL wait; it is accepted only in IDLE.
REQ-020 dbg_rdata SHALL equal mem[dbg_addr] combinationally, and SHALL reflect a write one cycle after that beat's handshake.

Reset
REQ-021 areset=1 at a rising edge SHALL force IDLE, awready=0, wready=0, bvalid=0, bresp=00, bid=0 and clear the counters; awready=1 on the first cycle after reset is released.
REQ-022 Reset mid-burst SHALL abandon the burst with no B response. Beats already written SHALL remain, and memory contents SHALL never be cleared by reset.

Verification
REQ-023 INCR, awaddr=0x10, awlen=3, awsize=2, wstrb=F, data A0..A3 -> words 4..7 = A0..A3, bresp=00, bid=awid, bvalid one cycle after last beat.
REQ-024 WRAP, awaddr=0x38, awlen=3, awsize=2 -> beats written to bytes 0x38, 0x3C, 0x30, 0x34; OKAY.
REQ-025 Single beat, wstrb=0101, prior word FFFFFFFF, wdata 12345678 -> word = FF34FF78.
REQ-026 awlen=3 with wlast on beat 1 -> burst ends after 2 beats, bresp=10; awaddr beyond MEM_WORDS -> no write, bresp=10.
REQ-027 bready held 0 for 5 cycles -> B outputs stable throughout, awready=0; bready=1 -> next AW accepted two cycles later.
REQ-028 areset asserted after beat 1 of 4 -> no bvalid, word 0 written, word 1 unchanged, awready=1 after reset is released.
